trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Trap sequencer that drives the machine-mode CSR block.
- Sits at the commit stage. Detects synchronous exceptions (illegal, ebreak, ecall), the machine timer interrupt, and mret.
- Issues the multi-cycle CSR write sequence (mepc/mcause, then mstatus), then a PC redirect plus pipeline flush with a valid/ready handshake.
- Stalls commit while a sequence is in flight.

Parameters:
XLEN, 64, width of PC and CSR datapaths

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
commit_valid  in  1  instruction presented at commit
commit_ready  out  1  commit accepted; high only in IDLE (combinational from state)
commit_pc  in  XLEN  PC of the presented instruction
illegal  in  1  illegal-instruction flag, qualified by commit_valid
ebreak  in  1  ebreak flag
ecall  in  1  ecall flag
mret  in  1  mret flag
timer_irq  in  1  MTIP level, synchronous to clk
mie_mtie  in  1  mie.MTIE
mstatus  in  XLEN  current mstatus from the CSR block
mepc  in  XLEN  current mepc
mtvec  in  XLEN  current mtvec
mepc_we  out  1  mepc write strobe
mepc_wdata  out  XLEN  mepc write data
mcause_we  out  1  mcause write strobe
mcause_wdata  out  XLEN  mcause write data
mstatus_we  out  1  mstatus write strobe
mstatus_wdata  out  XLEN  mstatus write data
flush  out  1  one-cycle pipeline flush pulse
redirect_valid  out  1  redirect request
redirect_ready  in  1  fetch accepts redirect
redirect_pc  out  XLEN  redirect target

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All strobes, flush and redirect_valid are 0; all data outputs are 0. Reset mid-sequence aborts it with no further CSR writes.
- All outputs except commit_ready are registered.
- Event sampling: only on the commit handshake, commit_valid && commit_ready.
- Interrupt condition: irq_take = timer_irq && mie_mtie && mstatus[3].
- Priority, highest first: irq_take, illegal, ebreak, ecall, mret. Only the highest is acted on.
- Handshake with no event: instruction retires, state stays IDLE.
- Latched at acceptance: cause, commit_pc, and an is_mret flag.
- Cause values:
  - irq: {1'b1, 59'b0, 4'd7} (0x8000_0000_0000_0007)
  - illegal: 2
  - ebreak: 3
  - ecall: 11
- An interrupted instruction is not retired; mepc = its PC.
- States and transitions:
  - IDLE: commit_ready=1. Trap event -> SAVE. mret -> RSTAT.
  - SAVE (1 cycle): mepc_we=1 with mepc_wdata=latched PC; mcause_we=1 with mcause_wdata=cause. -> TSTAT.
  - TSTAT (1 cycle): mstatus_we=1, wdata = mstatus with MPIE[7]<=MIE[3], MIE[3]<=0, MPP[12:11]<=2'b11; other bits unchanged. -> REDIR; target = trap target.
  - RSTAT (1 cycle): mstatus_we=1, wdata = mstatus with MIE[3]<=MPIE[7], MPIE[7]<=1, MPP<=2'b11 (M-only core). -> REDIR; target = mepc input sampled this cycle.
  - REDIR: flush=1 on the first cycle only. redirect_valid=1 with redirect_pc stable until redirect_valid && redirect_ready. Clear redirect_valid the following cycle and return to IDLE.
- Latency:
  - trap: acceptance at cycle N, mepc/mcause strobes at N+1, mstatus strobe at N+2, redirect_valid and flush at N+3.
  - mret: mstatus strobe at N+1, redirect at N+2.
- Trap target: {mtvec[XLEN-1:2], 2'b00}.
- Strobes are single-cycle; never two sequences overlap.
- redirect_ready held low: remain in REDIR indefinitely; flush does not repeat.
- timer_irq changes during a sequence are ignored until the next IDLE handshake.

Optional Feature:
- Macro TRAP_VECTORED_EN.
- Defined: when mtvec[1:0]==2'b01 and the trap is an interrupt, target = base + 4*cause[3:0]; timer gives base+0x1C. Exceptions always use base.
- mtvec[1:0] of 2'b10 or 2'b11 is treated as direct.
- Undefined: always direct mode, ignoring mtvec[1:0].

Test Plan:
- ecall at PC 0x8000_0100, mtvec=0x8000_0400, mstatus=0xA_0000_1808 -> N+1 mepc=0x8000_0100 and mcause=0xB; N+2 mstatus_wdata=0xA_0000_1880; N+3 flush=1, redirect_pc=0x8000_0400.
- mret with mepc=0x8000_0104, mstatus=0xA_0000_1880 -> N+1 mstatus_wdata=0xA_0000_1888; N+2 redirect_pc=0x8000_0104; commit_ready=0 during N+1..N+2.
- timer_irq=1, MTIE=1, MIE=1, ecall also set, PC 0x8000_0200 -> mcause=0x8000_0000_0000_0007, mepc=0x8000_0200. With MIE=0, the ecall is taken instead (mcause=0xB).
- redirect_ready held 0 for 5 cycles in REDIR -> redirect_valid stays 1 with a stable PC; flush pulses once; commit_ready=0 throughout; IDLE one cycle after ready.
- rst_n driven low during TSTAT -> outputs zero immediately (async); no mstatus_we after release; commit_ready=1.
- TRAP_VECTORED_EN with mtvec=0x8000_0401 and a timer interrupt -> redirect_pc=0x8000_041C. Illegal instruction with the same mtvec -> redirect_pc=0x8000_0400, mcause=2.

Source files
------------

// File: rtl/trap_ctrl_if.sv
// Commit, CSR-write and redirect signals between trap_ctrl (master) and the core/CSR block (slave).
interface trap_ctrl_if #(
  parameter int unsigned XLEN = 64
);
  logic            commit_valid;
  logic            commit_ready;
  logic [XLEN-1:0] commit_pc;
  logic            illegal;
  logic            ebreak;
  logic            ecall;
  logic            mret;
  logic            timer_irq;
  logic            mie_mtie;
  logic [XLEN-1:0] mstatus;
  logic [XLEN-1:0] mepc;
  logic [XLEN-1:0] mtvec;
  logic            mepc_we;
  logic [XLEN-1:0] mepc_wdata;
  logic            mcause_we;
  logic [XLEN-1:0] mcause_wdata;
  logic            mstatus_we;
  logic [XLEN-1:0] mstatus_wdata;
  logic            flush;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    input  commit_valid, commit_pc, illegal, ebreak, ecall, mret,
           timer_irq, mie_mtie, mstatus, mepc, mtvec, redirect_ready,
    output commit_ready, mepc_we, mepc_wdata, mcause_we, mcause_wdata,
           mstatus_we, mstatus_wdata, flush, redirect_valid, redirect_pc
  );

  modport slave (
    output commit_valid, commit_pc, illegal, ebreak, ecall, mret,
           timer_irq, mie_mtie, mstatus, mepc, mtvec, redirect_ready,
    input  commit_ready, mepc_we, mepc_wdata, mcause_we, mcause_wdata,
           mstatus_we, mstatus_wdata, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret sequencer: CSR write sequence, then flush + redirect handshake.
// Optional TRAP_VECTORED_EN: vectored interrupt targets when mtvec[1:0]==2'b01.
module trap_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  trap_ctrl_if.master  bus
);

  localparam logic [XLEN-1:0] CAUSE_IRQ     = {1'b1, {(XLEN-5){1'b0}}, 4'd7};
  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = XLEN'(2);
  localparam logic [XLEN-1:0] CAUSE_EBREAK  = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_ECALL   = XLEN'(11);

  typedef enum logic [2:0] {S_IDLE, S_SAVE, S_TSTAT, S_RSTAT, S_REDIR} state_e;

  state_e          state_q, state_d;
  logic            mepc_we_q, mepc_we_d;
  logic            mcause_we_q, mcause_we_d;
  logic            mstatus_we_q, mstatus_we_d;
  logic            flush_q, flush_d;
  logic            redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0] mepc_wdata_q, mepc_wdata_d;
  logic [XLEN-1:0] mcause_wdata_q, mcause_wdata_d;
  logic [XLEN-1:0] mstatus_wdata_q, mstatus_wdata_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic            accept_c;
  logic            irq_take_c;
  logic            trap_c;
  logic [XLEN-1:0] cause_c;
  logic [XLEN-1:0] trap_target_c;

  function automatic logic [XLEN-1:0] trap_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] m;
    m        = s;
    m[7]     = s[3];
    m[3]     = 1'b0;
    m[12:11] = 2'b11;
    return m;
  endfunction

  function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] s);
    logic [XLEN-1:0] m;
    m        = s;
    m[3]     = s[7];
    m[7]     = 1'b1;
    m[12:11] = 2'b11;
    return m;
  endfunction

  assign accept_c   = bus.commit_valid && (state_q == S_IDLE);
  assign irq_take_c = bus.timer_irq && bus.mie_mtie && bus.mstatus[3];
  assign trap_c     = irq_take_c || bus.illegal || bus.ebreak || bus.ecall;

  always_comb begin
    cause_c = CAUSE_ECALL;
    if (irq_take_c)       cause_c = CAUSE_IRQ;
    else if (bus.illegal) cause_c = CAUSE_ILLEGAL;
    else if (bus.ebreak)  cause_c = CAUSE_EBREAK;
  end

  // Trap target from the cause latched at acceptance (held in the mcause register).
  always_comb begin
    trap_target_c = bus.mtvec & ~XLEN'(3);
`ifdef TRAP_VECTORED_EN
    if ((bus.mtvec[1:0] == 2'b01) && mcause_wdata_q[XLEN-1])
      trap_target_c = trap_target_c + XLEN'({mcause_wdata_q[3:0], 2'b00});
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      mepc_we_q        <= 1'b0;
      mcause_we_q      <= 1'b0;
      mstatus_we_q     <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      mepc_wdata_q     <= '0;
      mcause_wdata_q   <= '0;
      mstatus_wdata_q  <= '0;
      redirect_pc_q    <= '0;
    end else begin
      state_q          <= state_d;
      mepc_we_q        <= mepc_we_d;
      mcause_we_q      <= mcause_we_d;
      mstatus_we_q     <= mstatus_we_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      mepc_wdata_q     <= mepc_wdata_d;
      mcause_wdata_q   <= mcause_wdata_d;
      mstatus_wdata_q  <= mstatus_wdata_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (trap_c)        state_d = S_SAVE;
          else if (bus.mret) state_d = S_RSTAT;
        end
      end
      S_SAVE:  state_d = S_TSTAT;
      S_TSTAT: state_d = S_REDIR;
      S_RSTAT: state_d = S_REDIR;
      S_REDIR: if (redirect_valid_q && bus.redirect_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; data registers hold between writes.
  always_comb begin
    mepc_we_d        = 1'b0;
    mcause_we_d      = 1'b0;
    mstatus_we_d     = 1'b0;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    mepc_wdata_d     = mepc_wdata_q;
    mcause_wdata_d   = mcause_wdata_q;
    mstatus_wdata_d  = mstatus_wdata_q;
    redirect_pc_d    = redirect_pc_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c && trap_c) begin
          mepc_we_d      = 1'b1;
          mepc_wdata_d   = bus.commit_pc;
          mcause_we_d    = 1'b1;
          mcause_wdata_d = cause_c;
        end else if (accept_c && bus.mret) begin
          mstatus_we_d    = 1'b1;
          mstatus_wdata_d = mret_mstatus(bus.mstatus);
        end
      end
      S_SAVE: begin
        mstatus_we_d    = 1'b1;
        mstatus_wdata_d = trap_mstatus(bus.mstatus);
      end
      S_TSTAT: begin
        flush_d          = 1'b1;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = trap_target_c;
      end
      S_RSTAT: begin
        flush_d          = 1'b1;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = bus.mepc;
      end
      S_REDIR: redirect_valid_d = !(redirect_valid_q && bus.redirect_ready);
      default: ;
    endcase
  end

  assign bus.commit_ready   = (state_q == S_IDLE);
  assign bus.mepc_we        = mepc_we_q;
  assign bus.mepc_wdata     = mepc_wdata_q;
  assign bus.mcause_we      = mcause_we_q;
  assign bus.mcause_wdata   = mcause_wdata_q;
  assign bus.mstatus_we     = mstatus_we_q;
  assign bus.mstatus_wdata  = mstatus_wdata_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: stimulus queues expected CSR/flush/redirect events, a negedge monitor checks them.
module tb_trap_ctrl;

  localparam int unsigned XLEN = 64;

  typedef enum int {K_MEPC, K_MCAUSE, K_MSTATUS, K_FLUSH, K_REDIR} kind_e;
  typedef struct {
    kind_e       kind;
    int          cyc;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic        rv_prev = 1'b0;
  logic [63:0] held_pc = '0;

  trap_ctrl_if #(.XLEN(XLEN)) bus ();

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input kind_e k, input int c, input logic [63:0] d);
    exp_t e;
    e.kind = k; e.cyc = c; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic mon_check(input kind_e k, input logic [63:0] d);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected %s: got %h at cyc %0d, required no event", k.name(), d, cyc);
    end else begin
      e = exp_q.pop_front();
      if (k == K_REDIR) held_pc = e.data;
      if (e.kind != k || e.cyc != cyc || e.data !== d) begin
        failures++;
        $display("FAIL event: got %s=%h at cyc %0d, required %s=%h at cyc %0d",
                 k.name(), d, cyc, e.kind.name(), e.data, e.cyc);
      end
    end
  endtask

  // Monitor: every output event is matched against the head of the expectation queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mepc_we)    mon_check(K_MEPC, bus.mepc_wdata);
      if (bus.mcause_we)  mon_check(K_MCAUSE, bus.mcause_wdata);
      if (bus.mstatus_we) mon_check(K_MSTATUS, bus.mstatus_wdata);
      if (bus.flush)      mon_check(K_FLUSH, 64'd0);
      if (bus.redirect_valid && !rv_prev) mon_check(K_REDIR, bus.redirect_pc);
      else if (bus.redirect_valid) chk("redirect_pc_stable", bus.redirect_pc, held_pc);
    end
    rv_prev = rst_n && bus.redirect_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] pc, input logic il, input logic eb,
                       input logic ec, input logic mr, output int n);
    bus.commit_pc    = pc;
    bus.illegal      = il;
    bus.ebreak       = eb;
    bus.ecall        = ec;
    bus.mret         = mr;
    bus.commit_valid = 1'b1;
    n = cyc;
  endtask

  task automatic release_commit();
    bus.commit_valid = 1'b0;
    bus.illegal = 1'b0; bus.ebreak = 1'b0; bus.ecall = 1'b0; bus.mret = 1'b0;
  endtask

  task automatic trap_expect(input int n, input logic [63:0] pc, input logic [63:0] cause,
                             input logic [63:0] mst, input logic [63:0] target);
    push(K_MEPC, n + 1, pc);
    push(K_MCAUSE, n + 1, cause);
    push(K_MSTATUS, n + 2, mst);
    push(K_FLUSH, n + 3, 64'd0);
    push(K_REDIR, n + 3, target);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (!(bus.commit_ready && !bus.redirect_valid) && k < 50) begin
      tick();
      k++;
    end
    checks++;
    if (k >= 50) begin
      failures++;
      $display("FAIL %s_timeout: got busy after %0d cycles, required idle", name, k);
    end
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_pending: got %0d unmatched events, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  logic [63:0] vec_target;
  int n;

  initial begin
`ifdef TRAP_VECTORED_EN
    vec_target = 64'h8000_041C;
`else
    vec_target = 64'h8000_0400;
`endif
    bus.commit_valid = 1'b0; bus.commit_pc = '0;
    bus.illegal = 1'b0; bus.ebreak = 1'b0; bus.ecall = 1'b0; bus.mret = 1'b0;
    bus.timer_irq = 1'b0; bus.mie_mtie = 1'b0;
    bus.mstatus = 64'hA_0000_1808; bus.mepc = '0; bus.mtvec = 64'h8000_0400;
    bus.redirect_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_commit_ready", 64'(bus.commit_ready), 64'd1);
    chk("rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
    chk("rst_mepc_wdata", bus.mepc_wdata, 64'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 64'd0);
    rst_n = 1'b1;
    tick();

    // ecall
    tick();
    drive(64'h8000_0100, 1'b0, 1'b0, 1'b1, 1'b0, n);
    trap_expect(n, 64'h8000_0100, 64'hB, 64'hA_0000_1880, 64'h8000_0400);
    tick(); release_commit();
    wait_idle("ecall");

    // mret
    bus.mepc = 64'h8000_0104; bus.mstatus = 64'hA_0000_1880;
    drive(64'h8000_0050, 1'b0, 1'b0, 1'b0, 1'b1, n);
    push(K_MSTATUS, n + 1, 64'hA_0000_1888);
    push(K_FLUSH, n + 2, 64'd0);
    push(K_REDIR, n + 2, 64'h8000_0104);
    tick(); release_commit();
    @(negedge clk); chk("mret_ready_n1", 64'(bus.commit_ready), 64'd0);
    tick();
    @(negedge clk); chk("mret_ready_n2", 64'(bus.commit_ready), 64'd0);
    tick();
    @(negedge clk); chk("mret_ready_n3", 64'(bus.commit_ready), 64'd1);
    wait_idle("mret");

    // timer interrupt wins over ecall
    bus.mstatus = 64'hA_0000_1808; bus.timer_irq = 1'b1; bus.mie_mtie = 1'b1;
    drive(64'h8000_0200, 1'b0, 1'b0, 1'b1, 1'b0, n);
    trap_expect(n, 64'h8000_0200, 64'h8000_0000_0000_0007, 64'hA_0000_1880, 64'h8000_0400);
    tick(); release_commit();
    wait_idle("irq");

    // MIE=0 masks the interrupt, ecall taken
    bus.mstatus = 64'hA_0000_1800;
    drive(64'h8000_0200, 1'b0, 1'b0, 1'b1, 1'b0, n);
    trap_expect(n, 64'h8000_0200, 64'hB, 64'hA_0000_1800, 64'h8000_0400);
    tick(); release_commit();
    wait_idle("irq_masked");
    bus.timer_irq = 1'b0;

    // exception priority
    bus.mstatus = 64'hA_0000_1808;
    drive(64'h8000_0300, 1'b1, 1'b1, 1'b1, 1'b1, n);
    trap_expect(n, 64'h8000_0300, 64'h2, 64'hA_0000_1880, 64'h8000_0400);
    tick(); release_commit();
    wait_idle("prio_illegal");
    drive(64'h8000_0304, 1'b0, 1'b1, 1'b1, 1'b0, n);
    trap_expect(n, 64'h8000_0304, 64'h3, 64'hA_0000_1880, 64'h8000_0400);
    tick(); release_commit();
    wait_idle("prio_ebreak");

    // handshake with no event retires silently
    drive(64'h8000_0600, 1'b0, 1'b0, 1'b0, 1'b0, n);
    tick(); release_commit();
    @(negedge clk); chk("noevent_ready", 64'(bus.commit_ready), 64'd1);
    wait_idle("noevent");

    // redirect back-pressure
    bus.redirect_ready = 1'b0;
    drive(64'h8000_0310, 1'b1, 1'b0, 1'b0, 1'b0, n);
    trap_expect(n, 64'h8000_0310, 64'h2, 64'hA_0000_1880, 64'h8000_0400);
    tick(); release_commit();
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_redirect_valid", 64'(bus.redirect_valid), 64'd1);
      chk("stall_commit_ready", 64'(bus.commit_ready), 64'd0);
      if (i < 4) tick();
    end
    tick(); bus.redirect_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("stall_release_valid", 64'(bus.redirect_valid), 64'd0);
    chk("stall_release_ready", 64'(bus.commit_ready), 64'd1);
    wait_idle("stall");

    // async reset during TSTAT aborts the sequence
    drive(64'h8000_0700, 1'b0, 1'b0, 1'b1, 1'b0, n);
    push(K_MEPC, n + 1, 64'h8000_0700);
    push(K_MCAUSE, n + 1, 64'hB);
    tick(); release_commit();
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_mstatus_we", 64'(bus.mstatus_we), 64'd0);
    chk("arst_mepc_wdata", bus.mepc_wdata, 64'd0);
    chk("arst_mcause_wdata", bus.mcause_wdata, 64'd0);
    chk("arst_mstatus_wdata", bus.mstatus_wdata, 64'd0);
    chk("arst_commit_ready", 64'(bus.commit_ready), 64'd1);
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    wait_idle("arst");

    // vectored mtvec: interrupt offsets by cause, exceptions use base
    bus.mtvec = 64'h8000_0401; bus.timer_irq = 1'b1; bus.mie_mtie = 1'b1;
    drive(64'h8000_0500, 1'b0, 1'b0, 1'b0, 1'b0, n);
    trap_expect(n, 64'h8000_0500, 64'h8000_0000_0000_0007, 64'hA_0000_1880, vec_target);
    tick(); release_commit();
    bus.timer_irq = 1'b0;
    wait_idle("vec_irq");
    drive(64'h8000_0504, 1'b1, 1'b0, 1'b0, 1'b0, n);
    trap_expect(n, 64'h8000_0504, 64'h2, 64'hA_0000_1880, 64'h8000_0400);
    tick(); release_commit();
    wait_idle("vec_illegal");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
